// File: rtl/mips_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_trace_pkg
// Purpose  : Shared record layout and kind encodings for the MIPS trace path.
// Revision : 1.0  initial release
// ============================================================================
package mips_trace_pkg;

  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;

  // Record layout: {kind, pc, addr, data}
  localparam int REC_W    = 97;
  localparam int OFF_DATA = 0;
  localparam int OFF_ADDR = 32;
  localparam int OFF_PC   = 64;
  localparam int OFF_KIND = 96;

  typedef logic [REC_W-1:0] rec_t;

  function automatic rec_t pack_rec(input logic        kind,
                                    input logic [31:0] pc,
                                    input logic [31:0] addr,
                                    input logic [31:0] data);
    return {kind, pc, addr, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo_2w1r.sv
`default_nettype none
// ============================================================================
// Module   : trace_fifo_2w1r
// Purpose  : FIFO with up to two ordered writes and one pop per cycle,
//            combinational head read, occupancy level.
// Revision : 1.0  initial release
// ============================================================================
module trace_fifo_2w1r #(
  parameter  int DEPTH = 16,
  parameter  int W     = 97,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       i_push_cnt,   // 0..2 records this cycle
  input  logic [W-1:0]     i_wdata0,     // goes to slot wptr
  input  logic [W-1:0]     i_wdata1,     // goes to slot wptr+1
  input  logic             i_pop,
  output logic [W-1:0]     o_rdata,
  output logic [LVL_W-1:0] o_level
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic [PTR_W-1:0] w_wptr1;

  // DEPTH is a power of two, so the pointer arithmetic wraps by itself.
  assign w_wptr1 = r_wptr + 1'b1;

  // Storage needs no reset: the head is only consumed while level != 0.
  always_ff @(posedge clk) begin
    if (i_push_cnt != 2'd0) r_mem[r_wptr]  <= i_wdata0;
    if (i_push_cnt == 2'd2) r_mem[w_wptr1] <= i_wdata1;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_wptr  <= r_wptr + PTR_W'(i_push_cnt);
      r_rptr  <= r_rptr + PTR_W'(i_pop);
      r_level <= r_level + LVL_W'(i_push_cnt) - LVL_W'(i_pop);
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/wb_trace_collector.sv
`default_nettype none
// ============================================================================
// Module   : wb_trace_collector
// Purpose  : Captures register-file and data-memory writes of the MIPS core
//            into an ordered trace stream; drops whole cycles on overflow.
// Revision : 1.0  initial release
// ============================================================================
module wb_trace_collector
  import mips_trace_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int DROP_W = 16,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [31:0]       pc,
  input  logic              reg_we,
  input  logic [4:0]        reg_waddr,
  input  logic [31:0]       reg_wdata,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic              trace_kind,
  output logic [31:0]       trace_pc,
  output logic [31:0]       trace_addr,
  output logic [31:0]       trace_data,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int FREE_W = LVL_W + 1;

  logic              w_req_r;
  logic              w_req_m;
  logic [1:0]        w_n;
  logic              w_fire;
  logic [FREE_W-1:0] w_free;
  logic              w_accept;
  logic              w_drop;
  logic [1:0]        w_push_cnt;
  rec_t              w_rec_reg;
  rec_t              w_rec_mem;
  rec_t              w_wdata0;
  rec_t              w_head;
  rec_t              w_head_g;
  logic [DROP_W:0]   w_drop_sum;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;

  // Writes to $0 are architecturally invisible and never traced.
  assign w_req_r   = en && reg_we && (reg_waddr != 5'd0);
  assign w_req_m   = en && mem_we;
  assign w_n       = {1'b0, w_req_r} + {1'b0, w_req_m};
  assign w_rec_reg = pack_rec(KIND_REG, pc, {27'b0, reg_waddr}, reg_wdata);
  assign w_rec_mem = pack_rec(KIND_MEM, pc, mem_addr, mem_wdata);

  assign trace_valid = (level != '0);
  assign w_fire      = trace_valid && trace_ready;

  // Admission is all-or-nothing per cycle; a pop this cycle frees a slot.
  always_comb begin
    w_free     = FREE_W'(DEPTH) - FREE_W'(level) + FREE_W'(w_fire);
    w_accept   = (FREE_W'(w_n) <= w_free);
    w_drop     = (w_n != 2'd0) && !w_accept;
    w_push_cnt = w_accept ? w_n : 2'd0;
    // Register record always precedes the memory record of the same cycle.
    w_wdata0   = w_req_r ? w_rec_reg : w_rec_mem;
    w_drop_sum = {1'b0, r_drop_cnt} + (DROP_W+1)'(w_n);
  end

  trace_fifo_2w1r #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push_cnt (w_push_cnt),
    .i_wdata0   (w_wdata0),
    .i_wdata1   (w_rec_mem),
    .i_pop      (w_fire),
    .o_rdata    (w_head),
    .o_level    (level)
  );

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
    end
  end

  // Outputs read zero while empty so stale storage never leaks out.
  assign w_head_g   = trace_valid ? w_head : '0;
  assign trace_kind = w_head_g[OFF_KIND];
  assign trace_pc   = w_head_g[OFF_PC +: 32];
  assign trace_addr = w_head_g[OFF_ADDR +: 32];
  assign trace_data = w_head_g[OFF_DATA +: 32];
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire
